// File: rtl/uart8_transceiver_if.sv
// Host/pin-side signal bundle for uart8_transceiver: serial pins, enables, byte data and status.
interface uart8_transceiver_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx;
    logic                 rxEn;
    logic [DATA_BITS-1:0] out;
    logic                 rxDone;
    logic                 rxBusy;
    logic                 rxErr;
    logic                 tx;
    logic                 txEn;
    logic                 txStart;
    logic [DATA_BITS-1:0] in;
    logic                 txDone;
    logic                 txBusy;

    modport master (
        output rx, rxEn, txEn, txStart, in,
        input  out, rxDone, rxBusy, rxErr, tx, txDone, txBusy
    );

    modport slave (
        input  rx, rxEn, txEn, txStart, in,
        output out, rxDone, rxBusy, rxErr, tx, txDone, txBusy
    );
endinterface

// File: rtl/uart8_transceiver.sv
// Full-duplex 8N1 UART: oversampling receiver and bit-period transmitter on one clock.
// Define UART8_PARITY_EN to add an even-parity bit after the data bits in both directions.
module uart8_transceiver #(
    parameter int unsigned CLOCK_RATE   = 100000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned OVERSAMPLING = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input logic                clk,
    input logic                rstn,
    uart8_transceiver_if.slave bus
);
    localparam int unsigned RXDIV   = CLOCK_RATE / (BAUD_RATE * OVERSAMPLING);
    localparam int unsigned TXDIV   = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned RXDIV_W = (RXDIV > 1) ? $clog2(RXDIV) : 1;
    localparam int unsigned TXDIV_W = (TXDIV > 1) ? $clog2(TXDIV) : 1;
    localparam int unsigned TICK_W  = $clog2(OVERSAMPLING);
    localparam int unsigned BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
`ifdef UART8_PARITY_EN
        RxParity,
`endif
        RxStop
    } rxState_e;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
`ifdef UART8_PARITY_EN
        TxParity,
`endif
        TxStop
    } txState_e;

    // ---------------- Receiver ----------------
    logic                 rxMetaQ, rxSyncQ, rxPrevQ;
    rxState_e             rxStateQ, rxStateD;
    logic [RXDIV_W-1:0]   rxDivQ, rxDivD;
    logic [TICK_W-1:0]    rxTickCntQ, rxTickCntD;
    logic [BIT_W-1:0]     rxBitCntQ, rxBitCntD;
    logic [DATA_BITS-1:0] rxShiftQ, rxShiftD;
    logic [DATA_BITS-1:0] outQ, outD;
    logic                 rxDoneQ, rxDoneD;
    logic                 rxErrQ, rxErrD;
    logic                 rxTick;
    logic                 rxFall;
`ifdef UART8_PARITY_EN
    logic                 rxParQ, rxParD;
`endif

    assign rxFall = rxPrevQ & ~rxSyncQ;

    always_comb begin
        rxStateD   = rxStateQ;
        rxDivD     = rxDivQ;
        rxTickCntD = rxTickCntQ;
        rxBitCntD  = rxBitCntQ;
        rxShiftD   = rxShiftQ;
        outD       = outQ;
        rxDoneD    = 1'b0;
        rxErrD     = 1'b0;
        rxTick     = 1'b0;
`ifdef UART8_PARITY_EN
        rxParD     = rxParQ;
`endif
        if (rxStateQ != RxIdle) begin
            if (rxDivQ == RXDIV_W'(RXDIV - 1)) begin
                rxDivD = '0;
                rxTick = 1'b1;
            end else begin
                rxDivD = rxDivQ + 1'b1;
            end
        end
        unique case (rxStateQ)
            RxIdle: begin
                rxDivD     = '0;
                rxTickCntD = '0;
                rxBitCntD  = '0;
                if (rxFall) rxStateD = RxStart;
            end
            RxStart: if (rxTick) begin
                // Half a bit in: a line that has already returned high was only a glitch.
                if (rxTickCntQ == TICK_W'(OVERSAMPLING / 2 - 1)) begin
                    rxTickCntD = '0;
                    rxStateD   = rxSyncQ ? RxIdle : RxData;
                end else begin
                    rxTickCntD = rxTickCntQ + 1'b1;
                end
            end
            RxData: if (rxTick) begin
                if (rxTickCntQ == TICK_W'(OVERSAMPLING - 1)) begin
                    rxTickCntD = '0;
                    rxShiftD   = {rxSyncQ, rxShiftQ[DATA_BITS-1:1]};
                    if (rxBitCntQ == BIT_W'(DATA_BITS - 1)) begin
                        rxBitCntD = '0;
`ifdef UART8_PARITY_EN
                        rxStateD  = RxParity;
`else
                        rxStateD  = RxStop;
`endif
                    end else begin
                        rxBitCntD = rxBitCntQ + 1'b1;
                    end
                end else begin
                    rxTickCntD = rxTickCntQ + 1'b1;
                end
            end
`ifdef UART8_PARITY_EN
            RxParity: if (rxTick) begin
                if (rxTickCntQ == TICK_W'(OVERSAMPLING - 1)) begin
                    rxTickCntD = '0;
                    rxParD     = rxSyncQ;
                    rxStateD   = RxStop;
                end else begin
                    rxTickCntD = rxTickCntQ + 1'b1;
                end
            end
`endif
            RxStop: if (rxTick) begin
                if (rxTickCntQ == TICK_W'(OVERSAMPLING - 1)) begin
                    rxTickCntD = '0;
                    rxStateD   = RxIdle;
`ifdef UART8_PARITY_EN
                    if (rxSyncQ && (rxParQ == ^rxShiftQ)) begin
`else
                    if (rxSyncQ) begin
`endif
                        outD    = rxShiftQ;
                        rxDoneD = 1'b1;
                    end else begin
                        rxErrD  = 1'b1;
                    end
                end else begin
                    rxTickCntD = rxTickCntQ + 1'b1;
                end
            end
            default: rxStateD = RxIdle;
        endcase
        if (!bus.rxEn) begin
            rxStateD   = RxIdle;
            rxDivD     = '0;
            rxTickCntD = '0;
            rxBitCntD  = '0;
            rxDoneD    = 1'b0;
            rxErrD     = 1'b0;
            outD       = outQ;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxMetaQ    <= 1'b1;
            rxSyncQ    <= 1'b1;
            rxPrevQ    <= 1'b1;
            rxStateQ   <= RxIdle;
            rxDivQ     <= '0;
            rxTickCntQ <= '0;
            rxBitCntQ  <= '0;
            rxShiftQ   <= '0;
            outQ       <= '0;
            rxDoneQ    <= 1'b0;
            rxErrQ     <= 1'b0;
`ifdef UART8_PARITY_EN
            rxParQ     <= 1'b0;
`endif
        end else begin
            rxMetaQ    <= bus.rx;
            rxSyncQ    <= rxMetaQ;
            rxPrevQ    <= rxSyncQ;
            rxStateQ   <= rxStateD;
            rxDivQ     <= rxDivD;
            rxTickCntQ <= rxTickCntD;
            rxBitCntQ  <= rxBitCntD;
            rxShiftQ   <= rxShiftD;
            outQ       <= outD;
            rxDoneQ    <= rxDoneD;
            rxErrQ     <= rxErrD;
`ifdef UART8_PARITY_EN
            rxParQ     <= rxParD;
`endif
        end
    end

    // ---------------- Transmitter ----------------
    txState_e             txStateQ, txStateD;
    logic [TXDIV_W-1:0]   txDivQ, txDivD;
    logic [BIT_W-1:0]     txBitCntQ, txBitCntD;
    logic [DATA_BITS-1:0] txShiftQ, txShiftD;
    logic                 txQ, txD;
    logic                 txDoneQ, txDoneD;
    logic                 txBitEnd;
`ifdef UART8_PARITY_EN
    logic                 txParQ, txParD;
`endif

    assign txBitEnd = (txDivQ == TXDIV_W'(TXDIV - 1));

    always_comb begin
        txStateD  = txStateQ;
        txDivD    = txDivQ;
        txBitCntD = txBitCntQ;
        txShiftD  = txShiftQ;
        txDoneD   = 1'b0;
        txD       = 1'b1;
`ifdef UART8_PARITY_EN
        txParD    = txParQ;
`endif
        if (txStateQ != TxIdle) txDivD = txBitEnd ? '0 : txDivQ + 1'b1;
        unique case (txStateQ)
            TxIdle: begin
                txDivD    = '0;
                txBitCntD = '0;
                if (bus.txStart) begin
                    txShiftD = bus.in;
`ifdef UART8_PARITY_EN
                    txParD   = ^bus.in;
`endif
                    txStateD = TxStart;
                end
            end
            TxStart: if (txBitEnd) txStateD = TxData;
            TxData: if (txBitEnd) begin
                txShiftD = txShiftQ >> 1;
                if (txBitCntQ == BIT_W'(DATA_BITS - 1)) begin
                    txBitCntD = '0;
`ifdef UART8_PARITY_EN
                    txStateD  = TxParity;
`else
                    txStateD  = TxStop;
`endif
                end else begin
                    txBitCntD = txBitCntQ + 1'b1;
                end
            end
`ifdef UART8_PARITY_EN
            TxParity: if (txBitEnd) txStateD = TxStop;
`endif
            TxStop: if (txBitEnd) begin
                txStateD = TxIdle;
                txDoneD  = 1'b1;
            end
            default: txStateD = TxIdle;
        endcase
        if (!bus.txEn) begin
            txStateD  = TxIdle;
            txDivD    = '0;
            txBitCntD = '0;
            txDoneD   = 1'b0;
        end
        // Line level is registered from the next state so tx changes cleanly on the edge.
        case (txStateD)
            TxStart:  txD = 1'b0;
            TxData:   txD = txShiftD[0];
`ifdef UART8_PARITY_EN
            TxParity: txD = txParD;
`endif
            default:  txD = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txStateQ  <= TxIdle;
            txDivQ    <= '0;
            txBitCntQ <= '0;
            txShiftQ  <= '0;
            txQ       <= 1'b1;
            txDoneQ   <= 1'b0;
`ifdef UART8_PARITY_EN
            txParQ    <= 1'b0;
`endif
        end else begin
            txStateQ  <= txStateD;
            txDivQ    <= txDivD;
            txBitCntQ <= txBitCntD;
            txShiftQ  <= txShiftD;
            txQ       <= txD;
            txDoneQ   <= txDoneD;
`ifdef UART8_PARITY_EN
            txParQ    <= txParD;
`endif
        end
    end

    assign bus.out    = outQ;
    assign bus.rxDone = rxDoneQ;
    assign bus.rxErr  = rxErrQ;
    assign bus.rxBusy = (rxStateQ != RxIdle);
    assign bus.tx     = txQ;
    assign bus.txDone = txDoneQ;
    assign bus.txBusy = (txStateQ != TxIdle);
endmodule

// File: tb/tb_uart8_transceiver.sv
// Directed + randomized bench for uart8_transceiver with a frame-level reference model.
module tb_uart8_transceiver;
    localparam int unsigned CLK_RATE = 3200000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned OS       = 16;
    localparam int unsigned DB       = 8;
    localparam int          T        = CLK_RATE / BAUD;
`ifdef UART8_PARITY_EN
    localparam int          NBITS    = DB + 3;
`else
    localparam int          NBITS    = DB + 2;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       loopBack = 1'b0;
    logic [7:0] inDrv = 8'h00;
    logic [7:0] modelOut = 8'h00;
    int         nCompared = 0;
    int         nMismatched = 0;
    int         rxDoneCnt = 0;
    int         rxErrCnt = 0;
    int         txDoneCnt = 0;
    int         rxBusyCyc = 0;

    uart8_transceiver_if #(.DATA_BITS(DB)) bus ();

    uart8_transceiver #(
        .CLOCK_RATE  (CLK_RATE),
        .BAUD_RATE   (BAUD),
        .OVERSAMPLING(OS),
        .DATA_BITS   (DB)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    assign bus.in = loopBack ? bus.out : inDrv;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rxDone === 1'b1) rxDoneCnt <= rxDoneCnt + 1;
        if (bus.rxErr === 1'b1) rxErrCnt <= rxErrCnt + 1;
        if (bus.txDone === 1'b1) txDoneCnt <= txDoneCnt + 1;
        if (bus.rxBusy === 1'b1) rxBusyCyc <= rxBusyCyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line level of bit k of a frame: start, data LSB first, [even parity], stop.
    function automatic logic frameBit(input logic [7:0] d, input logic stopBit, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return logic'((d >> (k - 1)) & 8'h01);
`ifdef UART8_PARITY_EN
        if (k == DB + 1) return ^d;
`endif
        return stopBit;
    endfunction

    task automatic driveRx(input logic [7:0] d, input logic stopBit);
        for (int k = 0; k < NBITS; k++) begin
            bus.rx = frameBit(d, stopBit, k);
            repeat (T) @(negedge clk);
        end
        bus.rx = 1'b1;
    endtask

    task automatic rxFrame(input logic [7:0] d, input logic stopBit, input string tag);
        int done0, err0, busy0, busyN;
        logic [7:0] expOut;
        done0  = rxDoneCnt;
        err0   = rxErrCnt;
        busy0  = rxBusyCyc;
        expOut = stopBit ? d : modelOut;
        driveRx(d, stopBit);
        repeat (4) @(negedge clk);
        busyN = rxBusyCyc - busy0;
        chk({tag, "_rxDone"}, rxDoneCnt - done0, stopBit ? 1 : 0);
        chk({tag, "_rxErr"}, rxErrCnt - err0, stopBit ? 0 : 1);
        chk({tag, "_out"}, bus.out, expOut);
        chk({tag, "_busyWin"}, (busyN > (NBITS - 1) * T) && (busyN < NBITS * T), 1);
        chk({tag, "_busyEnd"}, bus.rxBusy, 0);
        modelOut = expOut;
    endtask

    // Entered on a negedge; frame starts at the following posedge.
    task automatic txFrame(input logic [7:0] d, input logic lb, input string tag);
        int done0;
        done0       = txDoneCnt;
        loopBack    = lb;
        inDrv       = d;
        bus.txStart = 1'b1;
        @(negedge clk);
        bus.txStart = 1'b0;
        if (!lb) inDrv = 8'($urandom);
        repeat (T / 2) @(negedge clk);
        for (int k = 0; k < NBITS; k++) begin
            chk($sformatf("%s_txBit%0d", tag, k), bus.tx, frameBit(d, 1'b1, k));
            chk($sformatf("%s_txBusy%0d", tag, k), bus.txBusy, 1);
            if (k == 3) begin
                // A second request mid-frame must be ignored.
                inDrv       = ~d;
                bus.txStart = 1'b1;
                @(negedge clk);
                bus.txStart = 1'b0;
                repeat (T - 1) @(negedge clk);
            end else if (k < NBITS - 1) begin
                repeat (T) @(negedge clk);
            end
        end
        repeat (T / 2) @(negedge clk);
        chk({tag, "_txDonePulse"}, bus.txDone, 1);
        chk({tag, "_txBusyEnd"}, bus.txBusy, 0);
        chk({tag, "_txIdle"}, bus.tx, 1);
        @(negedge clk);
        chk({tag, "_txDoneCnt"}, txDoneCnt - done0, 1);
        loopBack = 1'b0;
    endtask

    initial begin
        int done0, err0, busy0, tdone0;
        logic seen;
        rstn        = 1'b0;
        bus.rx      = 1'b1;
        bus.rxEn    = 1'b1;
        bus.txEn    = 1'b1;
        bus.txStart = 1'b0;
        #23;
        chk("rst_tx", bus.tx, 1);
        chk("rst_out", bus.out, 0);
        chk("rst_rxDone", bus.rxDone, 0);
        chk("rst_rxBusy", bus.rxBusy, 0);
        chk("rst_rxErr", bus.rxErr, 0);
        chk("rst_txDone", bus.txDone, 0);
        chk("rst_txBusy", bus.txBusy, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        rxFrame(8'h55, 1'b1, "rx55");
        txFrame(modelOut, 1'b1, "lb55");
        rxFrame(8'h96, 1'b1, "rx96");
        txFrame(modelOut, 1'b1, "lb96");
        rxFrame(8'hA3, 1'b0, "ferrA3");

        // Short low glitch: START check must see the line high again.
        done0 = rxDoneCnt; err0 = rxErrCnt; busy0 = rxBusyCyc;
        bus.rx = 1'b0;
        repeat (10) @(negedge clk);
        bus.rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy", bus.rxBusy, 0);
        chk("glitch_rxDone", rxDoneCnt - done0, 0);
        chk("glitch_rxErr", rxErrCnt - err0, 0);
        chk("glitch_busyWin", (rxBusyCyc - busy0 > 0) && (rxBusyCyc - busy0 <= OS / 2 * 2 + 8), 1);
        chk("glitch_out", bus.out, modelOut);

        // Full-duplex randomized frames.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] rd, td;
            logic       sb;
            rd = 8'($urandom);
            td = 8'($urandom);
            sb = ($urandom_range(3) != 0);
            fork
                rxFrame(rd, sb, $sformatf("rnd%0d", i));
                txFrame(td, 1'b0, $sformatf("rndtx%0d", i));
            join
        end

        // txStart held across completion, then abort the second frame with txEn.
        inDrv = 8'h5A;
        bus.txStart = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < NBITS * T + 8; c++) begin
            @(negedge clk);
            if (bus.txDone === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_txDoneSeen", seen, 1);
        chk("b2b_busyLow", bus.txBusy, 0);
        @(negedge clk);
        chk("b2b_restartBusy", bus.txBusy, 1);
        chk("b2b_restartTx", bus.tx, 0);
        bus.txStart = 1'b0;
        tdone0 = txDoneCnt;
        repeat (3 * T) @(negedge clk);
        bus.txEn = 1'b0;
        @(negedge clk);
        chk("abort_tx", bus.tx, 1);
        chk("abort_busy", bus.txBusy, 0);
        repeat (NBITS * T) @(negedge clk);
        chk("abort_noDone", txDoneCnt - tdone0, 0);
        bus.txEn = 1'b1;

        // Receiver disabled mid-frame: frame discarded silently.
        done0 = rxDoneCnt; err0 = rxErrCnt;
        fork
            driveRx(8'h0F, 1'b1);
            begin
                repeat (4 * T) @(negedge clk);
                chk("rxEn_busyBefore", bus.rxBusy, 1);
                bus.rxEn = 1'b0;
                @(negedge clk);
                chk("rxEn_busyOff", bus.rxBusy, 0);
            end
        join
        repeat (4) @(negedge clk);
        bus.rxEn = 1'b1;
        repeat (4) @(negedge clk);
        chk("rxEn_noDone", rxDoneCnt - done0, 0);
        chk("rxEn_noErr", rxErrCnt - err0, 0);
        chk("rxEn_out", bus.out, modelOut);

        // Asynchronous reset with both directions mid-frame.
        done0 = rxDoneCnt; err0 = rxErrCnt; tdone0 = txDoneCnt;
        fork
            driveRx(8'hC3, 1'b1);
            begin
                inDrv = 8'($urandom);
                bus.txStart = 1'b1;
                @(negedge clk);
                bus.txStart = 1'b0;
                repeat (5 * T) @(negedge clk);
                chk("arst_rxBusyBefore", bus.rxBusy, 1);
                chk("arst_txBusyBefore", bus.txBusy, 1);
                #2 rstn = 1'b0;
                #1;
                chk("arst_tx", bus.tx, 1);
                chk("arst_out", bus.out, 0);
                chk("arst_rxBusy", bus.rxBusy, 0);
                chk("arst_txBusy", bus.txBusy, 0);
                chk("arst_rxDone", bus.rxDone, 0);
                chk("arst_rxErr", bus.rxErr, 0);
                chk("arst_txDone", bus.txDone, 0);
            end
        join
        @(negedge clk);
        rstn = 1'b1;
        modelOut = 8'h00;
        repeat (4) @(negedge clk);
        chk("arst_noRxDone", rxDoneCnt - done0, 0);
        chk("arst_noRxErr", rxErrCnt - err0, 0);
        chk("arst_noTxDone", txDoneCnt - tdone0, 0);

        rxFrame(8'h3C, 1'b1, "post");
        txFrame(modelOut, 1'b1, "lbpost");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/uart8_transceiver.md
Name: uart8_transceiver

Overview:
- Full-duplex 8N1 UART with independent receiver and transmitter sharing one clock.
- Receiver oversamples the `rx` line, de-serialises frames onto `out`, and flags framing errors.
- Transmitter serialises `in` onto `tx` on a start strobe.
- Sits between a serial pin pair and a byte-wide host interface; the host may loop `out` back to `in`.

Parameters:
- CLOCK_RATE, 100000000 — clk frequency in Hz.
- BAUD_RATE, 115200 — serial bit rate in bit/s.
- OVERSAMPLING, 16 — receiver samples per bit; must be an even value ≥ 4.
- DATA_BITS, 8 — payload bits per frame.

Ports:
- clk  in  1  — system clock; all logic is rising-edge.
- rstn  in  1  — asynchronous active-low reset.
- rx  in  1  — serial input; idles high.
- rxEn  in  1  — receiver enable.
- out  out  DATA_BITS  — last received byte.
- rxDone  out  1  — one-cycle pulse: frame received.
- rxBusy  out  1  — receiver is inside a frame.
- rxErr  out  1  — one-cycle pulse: framing error.
- tx  out  1  — serial output; idles high.
- txEn  in  1  — transmitter enable.
- txStart  in  1  — start request, level-sampled.
- in  in  DATA_BITS  — byte to send.
- txDone  out  1  — one-cycle pulse: frame sent.
- txBusy  out  1  — transmitter is inside a frame.

Behaviour:
- Clocking and reset: one clock domain (`clk`); reset is asynchronous and active-low on `rstn`.
- Reset values: tx=1, out=0; rxDone, rxBusy, rxErr, txDone, txBusy all 0; both FSMs in IDLE; all counters 0.
- Baud ticks:
  - RX tick every RXDIV = CLOCK_RATE/(BAUD_RATE*OVERSAMPLING) clocks (integer division; 54 at defaults).
  - TX bit period TXDIV = CLOCK_RATE/BAUD_RATE clocks (868 at defaults).
  - Each divider counter is held at 0 while its FSM is idle.
- rx synchronisation: `rx` passes through a 2-flop synchroniser before use (2-cycle detection latency).
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised high-to-low edge while rxEn=1; rxBusy rises.
  - START: after OVERSAMPLING/2 ticks, re-sample rx. If 0 → DATA. If 1 (glitch) → IDLE with no rxErr.
  - DATA: sample every OVERSAMPLING ticks (bit centre); shift into the LSB-first shift register; after DATA_BITS samples → STOP.
  - STOP: sample after OVERSAMPLING ticks.
    - If 1: load out, pulse rxDone for 1 cycle.
    - If 0: pulse rxErr for 1 cycle; out unchanged.
    - Either way → IDLE; rxBusy falls in the same cycle as the pulse.
  - rxEn=0 at any time: FSM forced to IDLE next cycle, rxBusy=0, partial frame discarded, no pulses.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If txEn=1 and txStart=1, latch `in` into the shift register, txBusy=1, → START.
  - Each of START (tx=0), DATA (DATA_BITS bits, LSB first) and STOP (tx=1) lasts exactly TXDIV clocks per bit.
  - End of STOP: txDone pulses 1 cycle, txBusy=0, → IDLE.
  - txStart while busy is ignored. txStart held high across completion starts a new frame in the cycle after txDone.
  - Changes to `in` after latching do not affect the frame in flight.
  - txEn=0 mid-frame: abort, tx=1 next cycle, txBusy=0, no txDone.
- RX and TX operate fully independently; simultaneous rx frames and tx frames are legal.
- Reset asserted mid-frame: both FSMs return to reset values immediately, with no pulses.

Optional Feature:
- Macro: UART8_PARITY_EN.
- When defined:
  - An even-parity bit is inserted after the data bits in both directions.
  - TX sends the XOR of the data bits.
  - RX checks the parity bit; a mismatch pulses rxErr instead of rxDone and leaves out unchanged.
  - A bad stop bit still pulses rxErr.
- When undefined: plain 8N1 framing, no parity logic synthesised.

Test Plan:
- Receive 0x55: drive start bit, then bits 1,0,1,0,1,0,1,0, then stop=1, 868 clocks per bit → rxDone pulse, out=0x55, rxBusy high for the frame, rxErr=0.
- Loopback transmit (in tied to out=0x55), pulse txStart 1 cycle → tx sequence 0,1,0,1,0,1,0,1,0,1, each 868 clocks; txBusy high throughout; single txDone pulse.
- Receive 0x96 (bits 0,1,1,0,1,0,0,1) then transmit via loopback → out=0x96; tx emits 0,0,1,1,0,1,0,0,1,1.
- Framing error: frame for 0xA3 with stop bit held 0 → rxErr pulse, no rxDone, out retains previous value.
- Glitch: rx low for 10 clocks only → no rxBusy after START check, no rxDone, no rxErr.
- Enables/reset: deassert txEn mid-frame → tx=1, txBusy=0, no txDone. Assert rstn=0 mid-rx → all outputs return to reset values asynchronously.
